// File: rtl/bht_controller.sv
`default_nettype none
// ============================================================================
// Module   : bht_controller
// Purpose  : Branch history table controller. Direct-mapped table of 2-bit
//            saturating counters indexed by pc[IDX_W+1:2]. One combinational
//            prediction lookup and one resolved-branch update per cycle. An
//            init sweep writes weakly-not-taken (01) to every entry after
//            reset or a clear request, blocking lookups and updates meanwhile.
// Ports    : clk, rst_n (async active-low)
//            clear_req        - pulse, reinitialize the whole table
//            busy             - init sweep in progress
//            lookup_pc        - fetch PC; predicted_taken is its prediction
//            upd_valid/upd_pc/upd_taken - resolved branch from execute
//            upd_ready        - update accepted this cycle (= !busy)
// Config   : BHT_BYPASS_EN - when defined, a same-cycle accepted update to the
//            looked-up index forwards its post-update counter to the
//            prediction. Undefined: lookup sees the stored (pre-update) value.
// Revision : 1.0 - initial release
// ============================================================================
module bht_controller #(
    parameter int PC_W  = 32,
    parameter int IDX_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear_req,
    output logic            busy,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            predicted_taken,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    output logic            upd_ready
);

    localparam int             DEPTH      = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] C_PTR_LAST = IDX_W'(DEPTH - 1);
    localparam logic [1:0]     C_WEAK_NT  = 2'b01;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [1:0]       table_q [DEPTH];
    logic [1:0]       table_d [DEPTH];

    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [1:0]       upd_cur;
    logic [1:0]       upd_next;
    logic             upd_write;
    logic             bypass_hit;
    logic [1:0]       lk_ctr;

    // PC bits outside the index field are intentionally ignored (no tags).
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0],
                              upd_pc[PC_W-1:IDX_W+2], upd_pc[1:0]};

    assign lk_idx  = lookup_pc[IDX_W+1:2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_cur = table_q[upd_idx];

    assign busy      = (state_q == ST_INIT);
    assign upd_ready = ~busy;

    // A clear in the same cycle wins over an accepted update.
    assign upd_write = upd_valid & upd_ready & ~clear_req;

    always_comb begin
        upd_next = upd_cur;
        if (upd_taken) begin
            if (upd_cur != 2'b11) upd_next = upd_cur + 2'b01;
        end else begin
            if (upd_cur != 2'b00) upd_next = upd_cur - 2'b01;
        end
    end

`ifdef BHT_BYPASS_EN
    assign bypass_hit = upd_write & (upd_idx == lk_idx);
`else
    assign bypass_hit = 1'b0;
`endif

    assign lk_ctr          = bypass_hit ? upd_next : table_q[lk_idx];
    assign predicted_taken = (state_q == ST_RUN) & lk_ctr[1];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            table_d[i] = table_q[i];
        end
        case (state_q)
            ST_INIT: begin
                table_d[ptr_q] = C_WEAK_NT;
                if (clear_req) begin
                    ptr_d = '0;
                end else if (ptr_q == C_PTR_LAST) begin
                    state_d = ST_RUN;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (clear_req) begin
                    state_d = ST_INIT;
                    ptr_d   = '0;
                end else if (upd_write) begin
                    table_d[upd_idx] = upd_next;
                end
            end
            default: begin
                state_d = ST_INIT;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Table storage needs no reset: the sweep defines it before any use.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            table_q[i] <= table_d[i];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bht_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_bht_controller
// Purpose  : Self-checking bench for bht_controller (PC_W=32, IDX_W=4).
//            Reference model: array of integer counters updated with
//            saturating arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bht_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear_req;
    logic        busy;
    logic [31:0] lookup_pc;
    logic        predicted_taken;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_ready;

    int checks = 0;
    int errors = 0;
    int model [16];

    bht_controller #(.PC_W(32), .IDX_W(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clear_req       (clear_req),
        .busy            (busy),
        .lookup_pc       (lookup_pc),
        .predicted_taken (predicted_taken),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_ready       (upd_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    function automatic int idx_of(input logic [31:0] pc);
        return int'(pc[5:2]);
    endfunction

    function automatic int sat(input int c, input bit t);
        if (t) return (c >= 3) ? 3 : c + 1;
        else   return (c <= 0) ? 0 : c - 1;
    endfunction

    // Expected prediction in RUN with no clear pending.
    function automatic bit exp_pred(input logic [31:0] lpc, input bit v,
                                    input logic [31:0] upc, input bit t);
        int li = idx_of(lpc);
        bit e  = (model[li] >= 2);
`ifdef BHT_BYPASS_EN
        if (v && idx_of(upc) == li) e = (sat(model[li], t) >= 2);
`endif
        return e;
    endfunction

    task automatic model_init();
        for (int i = 0; i < 16; i++) model[i] = 1;
    endtask

    // Called mid-cycle in RUN; applies one update and returns mid-cycle.
    task automatic do_update(input logic [31:0] pc, input bit t);
        upd_valid = 1'b1;
        upd_pc    = pc;
        upd_taken = t;
        @(posedge clk); #1;
        upd_valid = 1'b0;
        model[idx_of(pc)] = sat(model[idx_of(pc)], t);
    endtask

    // Counts busy cycles; bad counts cycles whose outputs break the rules.
    // While upd_valid is set, a fresh random upd_pc is presented each cycle.
    task automatic wait_sweep(output int n, output int bad);
        n = 0;
        bad = 0;
        for (int c = 0; c < 64; c++) begin
            #1;
            if (busy) begin
                n++;
                if (predicted_taken !== 1'b0 || upd_ready !== 1'b0) bad++;
            end else begin
                if (upd_ready !== 1'b1) bad++;
                break;
            end
            @(posedge clk); #1;
            upd_pc    = $urandom;
            lookup_pc = $urandom;
        end
    endtask

    task automatic test_reset();
        int n, bad;
        logic [31:0] r;
        rst_n = 1'b0; clear_req = 1'b0; upd_valid = 1'b0;
        upd_pc = '0; upd_taken = 1'b0; lookup_pc = 32'h40;
        #3;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
        checks++; if (upd_ready !== 1'b0) begin errors++; $display("FAIL reset_upd_ready: got %b expected 0", upd_ready); end
        checks++; if (predicted_taken !== 1'b0) begin errors++; $display("FAIL reset_pred: got %b expected 0", predicted_taken); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_sweep(n, bad);
        model_init();
        checks++; if (n != 16) begin errors++; $display("FAIL reset_sweep_len: got %0d expected 16", n); end
        checks++; if (bad != 0) begin errors++; $display("FAIL reset_sweep_outputs: got %0d bad cycles expected 0", bad); end
        for (int i = 0; i < 16; i++) begin
            r = $urandom;
            lookup_pc = {r[31:6], 4'(i), r[1:0]};
            #1;
            checks++;
            if (predicted_taken !== 1'b0) begin
                errors++; $display("FAIL reset_table idx %0d: got %b expected 0", i, predicted_taken);
            end
        end
    endtask

    task automatic test_taken_saturate();
        bit seq_t [6] = '{1, 1, 1, 1, 0, 0};
        bit seq_e [6] = '{1, 1, 1, 1, 1, 0};
        for (int i = 0; i < 6; i++) begin
            do_update(32'h40, seq_t[i]);
            lookup_pc = 32'h40;
            #1;
            checks++;
            if (predicted_taken !== seq_e[i] || predicted_taken !== (model[idx_of(32'h40)] >= 2)) begin
                errors++; $display("FAIL pc40_step %0d: got %b expected %b", i, predicted_taken, seq_e[i]);
            end
        end
    endtask

    task automatic test_alias();
        do_update(32'h04, 1'b1);
        do_update(32'h04, 1'b1);
        lookup_pc = 32'h44; #1;
        checks++; if (predicted_taken !== 1'b1) begin errors++; $display("FAIL alias_44: got %b expected 1", predicted_taken); end
        lookup_pc = 32'h08; #1;
        checks++; if (predicted_taken !== 1'b0) begin errors++; $display("FAIL alias_08: got %b expected 0", predicted_taken); end
    endtask

    task automatic test_nt_saturate();
        bit seq_t [5] = '{0, 0, 0, 1, 1};
        bit seq_e [5] = '{0, 0, 0, 0, 1};
        for (int i = 0; i < 5; i++) begin
            do_update(32'h08, seq_t[i]);
            lookup_pc = 32'h08;
            #1;
            checks++;
            if (predicted_taken !== seq_e[i]) begin
                errors++; $display("FAIL pc08_step %0d: got %b expected %b", i, predicted_taken, seq_e[i]);
            end
        end
    endtask

    task automatic test_clear();
        int n, bad;
        logic [31:0] r;
        clear_req = 1'b1; upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        // Keep presenting taken updates during the sweep; all must be dropped.
        wait_sweep(n, bad);
        upd_valid = 1'b0;
        model_init();
        checks++; if (n != 16) begin errors++; $display("FAIL clear_sweep_len: got %0d expected 16", n); end
        checks++; if (bad != 0) begin errors++; $display("FAIL clear_sweep_outputs: got %0d bad cycles expected 0", bad); end
        lookup_pc = 32'h10; #1;
        checks++; if (predicted_taken !== 1'b0) begin errors++; $display("FAIL clear_pc10: got %b expected 0", predicted_taken); end
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            r = $urandom;
            lookup_pc = {r[31:6], 4'(i), r[1:0]};
            #1;
            checks++;
            if (predicted_taken !== (model[i] >= 2)) begin
                errors++; $display("FAIL clear_table idx %0d: got %b expected %b", i, predicted_taken, model[i] >= 2);
            end
        end
    endtask

    task automatic test_clear_restart();
        int n, bad;
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        wait_sweep(n, bad);
        model_init();
        checks++; if (n != 16) begin errors++; $display("FAIL clear_restart_len: got %0d expected 16", n); end
        checks++; if (bad != 0) begin errors++; $display("FAIL clear_restart_outputs: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_same_cycle();
        bit e;
`ifdef BHT_BYPASS_EN
        e = 1'b1;
`else
        e = 1'b0;
`endif
        upd_valid = 1'b1; upd_pc = 32'h20; upd_taken = 1'b1; lookup_pc = 32'h20;
        #1;
        checks++; if (predicted_taken !== e) begin errors++; $display("FAIL same_cycle_now: got %b expected %b", predicted_taken, e); end
        @(posedge clk); #1;
        upd_valid = 1'b0;
        model[idx_of(32'h20)] = sat(model[idx_of(32'h20)], 1'b1);
        #1;
        checks++; if (predicted_taken !== 1'b1) begin errors++; $display("FAIL same_cycle_next: got %b expected 1", predicted_taken); end
    endtask

    task automatic test_random();
        bit e;
        int rand_errs = 0;
        logic [31:0] r;
        for (int k = 0; k < 400; k++) begin
            upd_valid = 1'($urandom_range(0, 1));
            upd_pc    = $urandom;
            upd_taken = 1'($urandom_range(0, 1));
            r = $urandom;
            if ($urandom_range(0, 3) == 0) lookup_pc = {r[31:6], upd_pc[5:2], r[1:0]};
            else                           lookup_pc = r;
            #1;
            e = exp_pred(lookup_pc, upd_valid, upd_pc, upd_taken);
            checks++;
            if (predicted_taken !== e || upd_ready !== 1'b1) begin
                errors++; rand_errs++;
                if (rand_errs < 10)
                    $display("FAIL random %0d lookup %h: got pred %b ready %b expected pred %b ready 1",
                             k, lookup_pc, predicted_taken, upd_ready, e);
            end
            @(posedge clk); #1;
            if (upd_valid) model[idx_of(upd_pc)] = sat(model[idx_of(upd_pc)], upd_taken);
        end
        upd_valid = 1'b0;
    endtask

    task automatic test_reset_mid_sweep();
        int n, bad;
        logic [31:0] r;
        do_update(32'h30, 1'b1);
        do_update(32'h30, 1'b1);
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b1 || upd_ready !== 1'b0 || predicted_taken !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs: got busy %b ready %b pred %b expected 1 0 0", busy, upd_ready, predicted_taken);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_sweep(n, bad);
        model_init();
        checks++; if (n != 16) begin errors++; $display("FAIL midreset_sweep_len: got %0d expected 16", n); end
        checks++; if (bad != 0) begin errors++; $display("FAIL midreset_sweep_outputs: got %0d bad cycles expected 0", bad); end
        for (int i = 0; i < 16; i++) begin
            r = $urandom;
            lookup_pc = {r[31:6], 4'(i), r[1:0]};
            #1;
            checks++;
            if (predicted_taken !== 1'b0) begin
                errors++; $display("FAIL midreset_table idx %0d: got %b expected 0", i, predicted_taken);
            end
        end
    endtask

    initial begin
        test_reset();
        test_taken_saturate();
        test_alias();
        test_nt_saturate();
        test_clear();
        test_same_cycle();
        test_random();
        test_clear_restart();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
